control_unit: RTL and testbench
===============================

# control_unit

Sequencing controller for the 32-bit RISC `DataPath`. It drives every control strobe that a bench would otherwise hand-drive: bus enables, register loads, `Gra`/`Grb`/`Grc` selects, `ALUCode`, and memory read/write. It steps through fetch (T0–T2) and a per-opcode execute sequence (T3–T7), decoding the opcode in `IR[31:27]` supplied by the datapath. It sits beside `DataPath` in the top level and replaces the bench-driven `present_state` sequencing.

## Interface
- No parameters.
- `clock`  in  1  system clock. Controller state updates on the falling edge; datapath registers capture on the rising edge.
- `clear`  in  1  reset, asynchronous, active-low (0 = reset).
- `IR`  in  32  instruction register contents from the datapath. Opcode is `IR[31:27]`.
- `ConOut`  in  1  branch-condition flag from the datapath.
- `HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn`  out  1 each  register load enables.
- `HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut`  out  1 each  bus drivers.
- `Gra, Grb, Grc, RIn, ROut, BAOut, Conin`  out  1 each  register-file select/control and condition latch.
- `memread, memwrite`  out  1 each  memory strobes.
- `ALUCode`  out  5  ALU operation code.
- `run`  out  1  high while executing; low in RESET and HALT.
- `initMem` is not driven by this block; the top level ties it to 0.

## Operation
- Reset:
  - All outputs are 0, including `run` and `ALUCode`.
  - State is RESET.
  - On the first falling edge with `clear`=1, state goes to T0.
- Fetch sequence:
  - T0: `PCOut`, `MARIn`, `ZIn`, `ALUCode`=11111 (increment).
  - T1: `ZLoOut`, `PCIn`, `memread`, `MDRIn`.
  - T2: `MDROut`, `IRIn`.
  - The opcode is sampled from `IR` on the falling edge that leaves T2 and held in an internal register for the whole execute sequence.
- Execute sequences:
  - Every unlisted strobe is 0. `ALUCode` is 0 unless specified.
  - After the last listed step, the next state is T0.
- ALU R-type (`add` 00011, `sub` 00100, `and` 00101, `or` 00110, `ror` 00111, `rol` 01000, `shr` 01001, `shra` 01010, `shl` 01011):
  - T3: `Grb`, `ROut`, `YIn`.
  - T4: `Grc`, `ROut`, `ZIn`, `ALUCode`=opcode.
  - T5: `ZLoOut`, `Gra`, `RIn`.
- `neg` 10001 / `not` 10010:
  - T3: `Grb`, `ROut`, `ZIn`, `ALUCode`=opcode.
  - T4: `ZLoOut`, `Gra`, `RIn`.
- Immediate ops (`addi` 01100, `andi` 01101, `ori` 01110):
  - T3: `Grb`, `ROut`, `YIn`.
  - T4: `COut`, `ZIn`, `ALUCode` = 00011 / 00101 / 00110 respectively.
  - T5: `ZLoOut`, `Gra`, `RIn`.
- `mul` 10000 / `div` 01111:
  - T3: `Gra`, `ROut`, `YIn`.
  - T4: `Grb`, `ROut`, `ZIn`, `ALUCode`=opcode.
  - T5: `ZLoOut`, `LoIn`.
  - T6: `ZHiOut`, `HiIn`.
- `ldi` 00001:
  - T3: `Grb`, `BAOut`, `YIn`.
  - T4: `COut`, `ZIn`, `ALUCode`=00011.
  - T5: `ZLoOut`, `Gra`, `RIn`.
- `ld` 00000:
  - T3–T4: same as `ldi`.
  - T5: `ZLoOut`, `MARIn`.
  - T6: `memread`, `MDRIn`.
  - T7: `MDROut`, `Gra`, `RIn`.
- `st` 00010:
  - T3–T5: same as `ld`.
  - T6: `Gra`, `ROut`, `MDRIn`.
  - T7: `memwrite`.
- `br` 10011:
  - T3: `Gra`, `ROut`, `Conin`.
  - T4: `PCOut`, `YIn`.
  - T5: `COut`, `ZIn`, `ALUCode`=00011.
  - T6: if `ConOut`=1, assert `ZLoOut` and `PCIn`; otherwise assert no strobes.
- `jr` 10100:
  - T3: `Gra`, `ROut`, `PCIn`.
- `jal` 10101:
  - T3: `PCOut`, `Grb`, `RIn`.
  - T4: `Gra`, `ROut`, `PCIn`.
- `in` 10110:
  - T3: `IPortOut`, `Gra`, `RIn`.
- `out` 10111:
  - T3: `Gra`, `ROut`, `OPortIn`.
- `mfhi` 11000 / `mflo` 11001:
  - T3: `HiOut` (resp. `LoOut`), `Gra`, `RIn`.
- `nop` 11010 and all undefined opcodes: next state after T2 is T0.
- `halt` 11011: next state after T2 is HALT. HALT has all strobes 0 and `run`=0, and is left only by reset.

## Timing
- State register: negedge of `clock`, asynchronously cleared.
- Outputs: decoded combinationally from state and the latched opcode only, so they are glitch-free and stable across the following posedge. No output depends combinationally on `IR`.
- `ConOut` is sampled combinationally during `br` T6 only; it must be stable by the posedge ending T6.
- Instruction length in cycles, fetch included:
  - ALU R-type and immediate ops: 6.
  - `neg`/`not`: 5.
  - `mul`/`div`, `ldi`: 7 and 6 respectively.
  - `ld`, `st`: 8.
  - `br`: 7.
  - `jr`, `in`, `out`, `mfhi`, `mflo`: 4.
  - `jal`: 5.
  - `nop`: 3.
- Reset mid-instruction: all outputs go to 0 immediately. No partial register write completes on the next posedge.

## Configuration
- `CTRL_MEM_WAIT_EN` defined:
  - Adds input `mem_ready` (1 bit).
  - States asserting `memread` or `memwrite` (T1, `ld` T6, `st` T7) hold, with all their strobes held, until `mem_ready`=1 at a falling edge.
- Not defined:
  - No `mem_ready` port.
  - Memory states last exactly one cycle.

## Structure
- Package `ctrl_pkg`:
  - opcode constants (5 bits);
  - ALU code constants, including `ALU_INC`=11111 and `ALU_ADD`=00011;
  - state enum (RESET, T0–T7, HALT).
- Sub-module `control_decode`:
  - purely combinational;
  - maps (state, opcode, `ConOut`) to the full strobe vector.
- `control_unit` holds the state register, opcode latch and wait logic.

## Test plan
- Reset and start: hold `clear`=0 for 3 cycles → all outputs 0 and `run`=0. Release → `run`=1; T0 asserts `PCOut`, `MARIn`, `ZIn` with `ALUCode`=11111.
- `add` (IR=0x18000000 class, opcode 00011) → T4 has `ALUCode`=00011 and `Grc`. T5 has `Gra`/`RIn`. T0 recurs 6 cycles after the previous T0.
- `ld` then `st` back-to-back → `memread` pulses in T1 and T6 for `ld`; `memwrite` is asserted only in `st` T7; total 16 cycles.
- `br` with `ConOut`=1 → `PCIn` asserted in T6. Repeat with `ConOut`=0 → T6 has all strobes 0.
- `halt` → `run` falls after T2 and stays low for 20 cycles. Asserting `clear` mid-`mul` at T5 → all outputs 0 asynchronously and `LoIn` is never seen.
- With `CTRL_MEM_WAIT_EN` defined, `mem_ready` low for 3 cycles during T1 → `memread`/`MDRIn` held for 4 cycles; T2 follows.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared constants for the RISC sequencing controller: opcodes, ALU codes,
// state encodings, the strobe vector layout and the per-opcode final step.
package ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011, OP_SUB  = 5'b00100, OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110, OP_ROR  = 5'b00111, OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001, OP_SHRA = 5'b01010, OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_DIV  = 5'b01111, OP_MUL  = 5'b10000, OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010, OP_BR   = 5'b10011, OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101, OP_IN   = 5'b10110, OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011, ALU_AND = 5'b00101, ALU_OR = 5'b00110;
    localparam logic [4:0] ALU_INC = 5'b11111;

    localparam logic [3:0] ST_RESET = 4'd0, ST_T0 = 4'd1, ST_T1 = 4'd2, ST_T2 = 4'd3;
    localparam logic [3:0] ST_T3 = 4'd4, ST_T4 = 4'd5, ST_T5 = 4'd6, ST_T6 = 4'd7;
    localparam logic [3:0] ST_T7 = 4'd8, ST_HALT = 4'd9;

    typedef struct packed {
        logic       run;
        logic [4:0] alu_code;
        logic       mem_write, mem_read, con_in, ba_out, r_out, r_in;
        logic       grc, grb, gra, c_out, iport_out, mdr_out, pc_out;
        logic       zlo_out, zhi_out, lo_out, hi_out;
        logic       ir_in, oport_in, y_in, mar_in, mdr_in, pc_in, z_in, lo_in, hi_in;
    } strobes_t;

    // Last execute step of each opcode; T2 means the instruction ends after fetch.
    function automatic logic [3:0] last_step(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:        last_step = ST_T5;
            OP_NEG, OP_NOT, OP_JAL:                  last_step = ST_T4;
            OP_MUL, OP_DIV, OP_BR:                   last_step = ST_T6;
            OP_LD, OP_ST:                            last_step = ST_T7;
            OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO:  last_step = ST_T3;
            default:                                 last_step = ST_T2;
        endcase
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational strobe decoder: (state, latched opcode, ConOut) -> strobe vector.
module control_decode
    import ctrl_pkg::*;
(
    input  logic [3:0]  state,
    input  logic [4:0]  opcode,
    input  logic        con_out,
    output logic [31:0] strobes
);

    strobes_t s_s;

    assign strobes = s_s;

    // Strobe decode for fetch and every execute sequence.
    always_comb begin
        s_s     = '0;
        s_s.run = 1'b1;
        case (state)
            ST_T0: begin s_s.pc_out = 1'b1; s_s.mar_in = 1'b1; s_s.z_in = 1'b1; s_s.alu_code = ALU_INC; end
            ST_T1: begin s_s.zlo_out = 1'b1; s_s.pc_in = 1'b1; s_s.mem_read = 1'b1; s_s.mdr_in = 1'b1; end
            ST_T2: begin s_s.mdr_out = 1'b1; s_s.ir_in = 1'b1; end
            ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        case (state)
                            ST_T3: begin s_s.grb = 1'b1; s_s.r_out = 1'b1; s_s.y_in = 1'b1; end
                            ST_T4: begin
                                s_s.z_in = 1'b1;
                                if (opcode == OP_ADDI) begin
                                    s_s.c_out = 1'b1; s_s.alu_code = ALU_ADD;
                                end else if (opcode == OP_ANDI) begin
                                    s_s.c_out = 1'b1; s_s.alu_code = ALU_AND;
                                end else if (opcode == OP_ORI) begin
                                    s_s.c_out = 1'b1; s_s.alu_code = ALU_OR;
                                end else begin
                                    s_s.grc = 1'b1; s_s.r_out = 1'b1; s_s.alu_code = opcode;
                                end
                            end
                            ST_T5: begin s_s.zlo_out = 1'b1; s_s.gra = 1'b1; s_s.r_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_NEG, OP_NOT: begin
                        case (state)
                            ST_T3: begin s_s.grb = 1'b1; s_s.r_out = 1'b1; s_s.z_in = 1'b1; s_s.alu_code = opcode; end
                            ST_T4: begin s_s.zlo_out = 1'b1; s_s.gra = 1'b1; s_s.r_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_MUL, OP_DIV: begin
                        case (state)
                            ST_T3: begin s_s.gra = 1'b1; s_s.r_out = 1'b1; s_s.y_in = 1'b1; end
                            ST_T4: begin s_s.grb = 1'b1; s_s.r_out = 1'b1; s_s.z_in = 1'b1; s_s.alu_code = opcode; end
                            ST_T5: begin s_s.zlo_out = 1'b1; s_s.lo_in = 1'b1; end
                            ST_T6: begin s_s.zhi_out = 1'b1; s_s.hi_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    // ldi, ld and st share the effective-address computation in T3-T4.
                    OP_LDI, OP_LD, OP_ST: begin
                        case (state)
                            ST_T3: begin s_s.grb = 1'b1; s_s.ba_out = 1'b1; s_s.y_in = 1'b1; end
                            ST_T4: begin s_s.c_out = 1'b1; s_s.z_in = 1'b1; s_s.alu_code = ALU_ADD; end
                            ST_T5: begin
                                s_s.zlo_out = 1'b1;
                                if (opcode == OP_LDI) begin
                                    s_s.gra = 1'b1; s_s.r_in = 1'b1;
                                end else begin
                                    s_s.mar_in = 1'b1;
                                end
                            end
                            ST_T6: begin
                                if (opcode == OP_LD) begin
                                    s_s.mem_read = 1'b1; s_s.mdr_in = 1'b1;
                                end else if (opcode == OP_ST) begin
                                    s_s.gra = 1'b1; s_s.r_out = 1'b1; s_s.mdr_in = 1'b1;
                                end else begin
                                    s_s.mdr_in = 1'b0;
                                end
                            end
                            ST_T7: begin
                                if (opcode == OP_LD) begin
                                    s_s.mdr_out = 1'b1; s_s.gra = 1'b1; s_s.r_in = 1'b1;
                                end else if (opcode == OP_ST) begin
                                    s_s.mem_write = 1'b1;
                                end else begin
                                    s_s.mem_write = 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                    OP_BR: begin
                        case (state)
                            ST_T3: begin s_s.gra = 1'b1; s_s.r_out = 1'b1; s_s.con_in = 1'b1; end
                            ST_T4: begin s_s.pc_out = 1'b1; s_s.y_in = 1'b1; end
                            ST_T5: begin s_s.c_out = 1'b1; s_s.z_in = 1'b1; s_s.alu_code = ALU_ADD; end
                            ST_T6: begin s_s.zlo_out = con_out; s_s.pc_in = con_out; end
                            default: ;
                        endcase
                    end
                    OP_JR:   if (state == ST_T3) begin s_s.gra = 1'b1; s_s.r_out = 1'b1; s_s.pc_in = 1'b1; end
                             else begin s_s.pc_in = 1'b0; end
                    OP_JAL: begin
                        case (state)
                            ST_T3: begin s_s.pc_out = 1'b1; s_s.grb = 1'b1; s_s.r_in = 1'b1; end
                            ST_T4: begin s_s.gra = 1'b1; s_s.r_out = 1'b1; s_s.pc_in = 1'b1; end
                            default: ;
                        endcase
                    end
                    OP_IN, OP_OUT, OP_MFHI, OP_MFLO: begin
                        if (state == ST_T3) begin
                            s_s.gra       = 1'b1;
                            s_s.r_in      = (opcode != OP_OUT);
                            s_s.r_out     = (opcode == OP_OUT);
                            s_s.oport_in  = (opcode == OP_OUT);
                            s_s.iport_out = (opcode == OP_IN);
                            s_s.hi_out    = (opcode == OP_MFHI);
                            s_s.lo_out    = (opcode == OP_MFLO);
                        end else begin
                            s_s.gra = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
            default: s_s = '0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Sequencing controller for the 32-bit RISC datapath: negedge state register,
// opcode latch and optional memory wait (enabled by CTRL_MEM_WAIT_EN).
module control_unit
    import ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        ConOut,
`ifdef CTRL_MEM_WAIT_EN
    input  logic        mem_ready,
`endif
    output logic        HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn,
    output logic        HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut,
    output logic        Gra, Grb, Grc, RIn, ROut, BAOut, Conin,
    output logic        memread, memwrite,
    output logic [4:0]  ALUCode,
    output logic        run
);

    logic [3:0]  state_r, state_next_s;
    logic [4:0]  opcode_r;
    logic [31:0] strobes_s;
    strobes_t    strb_s;
    logic        hold_s;
    logic        unused_ir_s;

    assign unused_ir_s = ^IR[26:0];
    assign strb_s      = strobes_s;

    control_decode u_decode (
        .state   (state_r),
        .opcode  (opcode_r),
        .con_out (ConOut),
        .strobes (strobes_s)
    );

    assign {run, ALUCode, memwrite, memread, Conin, BAOut, ROut, RIn, Grc, Grb, Gra,
            COut, IPortOut, MDROut, PCOut, ZLoOut, ZHiOut, LoOut, HiOut,
            IRIn, OPortIn, YIn, MARIn, MDRIn, PCIn, ZIn, LoIn, HiIn} = strobes_s;

`ifdef CTRL_MEM_WAIT_EN
    assign hold_s = (strb_s.mem_read | strb_s.mem_write) & ~mem_ready;
`else
    assign hold_s = 1'b0;
`endif

    // Next-state selection; T2 looks at the live IR because the opcode latch loads on that same edge.
    always_comb begin
        state_next_s = state_r;
        if (hold_s) begin
            state_next_s = state_r;
        end else begin
            case (state_r)
                ST_RESET: state_next_s = ST_T0;
                ST_T0:    state_next_s = ST_T1;
                ST_T1:    state_next_s = ST_T2;
                ST_T2: begin
                    if (IR[31:27] == OP_HALT) begin
                        state_next_s = ST_HALT;
                    end else if (last_step(IR[31:27]) == ST_T2) begin
                        state_next_s = ST_T0;
                    end else begin
                        state_next_s = ST_T3;
                    end
                end
                ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
                    if (state_r == last_step(opcode_r)) begin
                        state_next_s = ST_T0;
                    end else begin
                        state_next_s = state_r + 4'd1;
                    end
                end
                ST_HALT:  state_next_s = ST_HALT;
                default:  state_next_s = ST_RESET;
            endcase
        end
    end

    // State register and opcode latch, advancing on the falling edge.
    always_ff @(negedge clock or negedge clear) begin
        if (!clear) begin
            state_r  <= ST_RESET;
            opcode_r <= 5'b00000;
        end else begin
            state_r <= state_next_s;
            if (state_r == ST_T2) begin
                opcode_r <= IR[31:27];
            end
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: random instruction streams are expanded
// into expected per-cycle strobe traces and compared at each rising edge.
module tb_control_unit;

    logic        clock, clear, ConOut;
    logic [31:0] IR;
    logic        HiIn, LoIn, ZIn, PCIn, MDRIn, MARIn, YIn, OPortIn, IRIn;
    logic        HiOut, LoOut, ZHiOut, ZLoOut, PCOut, MDROut, IPortOut, COut;
    logic        Gra, Grb, Grc, RIn, ROut, BAOut, Conin, memread, memwrite, run;
    logic [4:0]  ALUCode;
`ifdef CTRL_MEM_WAIT_EN
    logic        mem_ready;
`endif

    int tests = 0;
    int fails = 0;

    control_unit dut (
        .clock(clock), .clear(clear), .IR(IR), .ConOut(ConOut),
`ifdef CTRL_MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .HiIn(HiIn), .LoIn(LoIn), .ZIn(ZIn), .PCIn(PCIn), .MDRIn(MDRIn), .MARIn(MARIn),
        .YIn(YIn), .OPortIn(OPortIn), .IRIn(IRIn), .HiOut(HiOut), .LoOut(LoOut),
        .ZHiOut(ZHiOut), .ZLoOut(ZLoOut), .PCOut(PCOut), .MDROut(MDROut),
        .IPortOut(IPortOut), .COut(COut), .Gra(Gra), .Grb(Grb), .Grc(Grc), .RIn(RIn),
        .ROut(ROut), .BAOut(BAOut), .Conin(Conin), .memread(memread), .memwrite(memwrite),
        .ALUCode(ALUCode), .run(run)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [31:0] HIIN = 32'd1 << 0,  LOIN = 32'd1 << 1,  ZIN = 32'd1 << 2;
    localparam logic [31:0] PCIN = 32'd1 << 3,  MDRIN = 32'd1 << 4, MARIN = 32'd1 << 5;
    localparam logic [31:0] YIN = 32'd1 << 6,   OPIN = 32'd1 << 7,  IRIN = 32'd1 << 8;
    localparam logic [31:0] HIOUT = 32'd1 << 9, LOOUT = 32'd1 << 10, ZHI = 32'd1 << 11;
    localparam logic [31:0] ZLO = 32'd1 << 12,  PCOUT = 32'd1 << 13, MDROUT = 32'd1 << 14;
    localparam logic [31:0] IPOUT = 32'd1 << 15, COUT = 32'd1 << 16, GRA = 32'd1 << 17;
    localparam logic [31:0] GRB = 32'd1 << 18,  GRC = 32'd1 << 19,  RIN = 32'd1 << 20;
    localparam logic [31:0] ROUT = 32'd1 << 21, BAOUT = 32'd1 << 22, CONIN = 32'd1 << 23;
    localparam logic [31:0] MRD = 32'd1 << 24,  MWR = 32'd1 << 25,  RUN = 32'd1 << 31;

    typedef struct packed {
        logic [31:0] vec;
        logic [31:0] ir;
        logic        con;
    } step_t;

    step_t       q[$];
    logic [31:0] cur_ir;
    logic        cur_con;

    function automatic logic [31:0] alu(input logic [4:0] c);
        return {1'b0, c, 26'd0};
    endfunction

    function automatic logic [31:0] observed();
        return {run, ALUCode, memwrite, memread, Conin, BAOut, ROut, RIn, Grc, Grb, Gra,
                COut, IPortOut, MDROut, PCOut, ZLoOut, ZHiOut, LoOut, HiOut,
                IRIn, OPortIn, YIn, MARIn, MDRIn, PCIn, ZIn, LoIn, HiIn};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [31:0] v);
        q.push_back('{vec: v | RUN, ir: cur_ir, con: cur_con});
    endtask

    // Expand one instruction into its cycle-by-cycle strobe trace.
    task automatic add_instr(input logic [4:0] op, input logic con);
        cur_ir  = {op, 27'($urandom)};
        cur_con = con;
        push(PCOUT | MARIN | ZIN | alu(5'b11111));
        push(ZLO | PCIN | MRD | MDRIN);
        push(MDROUT | IRIN);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
            5'b01010, 5'b01011: begin
                push(GRB | ROUT | YIN); push(GRC | ROUT | ZIN | alu(op)); push(ZLO | GRA | RIN);
            end
            5'b10001, 5'b10010: begin push(GRB | ROUT | ZIN | alu(op)); push(ZLO | GRA | RIN); end
            5'b01100: begin push(GRB | ROUT | YIN); push(COUT | ZIN | alu(5'b00011)); push(ZLO | GRA | RIN); end
            5'b01101: begin push(GRB | ROUT | YIN); push(COUT | ZIN | alu(5'b00101)); push(ZLO | GRA | RIN); end
            5'b01110: begin push(GRB | ROUT | YIN); push(COUT | ZIN | alu(5'b00110)); push(ZLO | GRA | RIN); end
            5'b10000, 5'b01111: begin
                push(GRA | ROUT | YIN); push(GRB | ROUT | ZIN | alu(op));
                push(ZLO | LOIN); push(ZHI | HIIN);
            end
            5'b00001: begin push(GRB | BAOUT | YIN); push(COUT | ZIN | alu(5'b00011)); push(ZLO | GRA | RIN); end
            5'b00000, 5'b00010: begin
                push(GRB | BAOUT | YIN); push(COUT | ZIN | alu(5'b00011)); push(ZLO | MARIN);
                if (op == 5'b00000) begin push(MRD | MDRIN); push(MDROUT | GRA | RIN); end
                else begin push(GRA | ROUT | MDRIN); push(MWR); end
            end
            5'b10011: begin
                push(GRA | ROUT | CONIN); push(PCOUT | YIN); push(COUT | ZIN | alu(5'b00011));
                push(con ? (ZLO | PCIN) : 32'd0);
            end
            5'b10100: push(GRA | ROUT | PCIN);
            5'b10101: begin push(PCOUT | GRB | RIN); push(GRA | ROUT | PCIN); end
            5'b10110: push(IPOUT | GRA | RIN);
            5'b10111: push(GRA | ROUT | OPIN);
            5'b11000: push(HIOUT | GRA | RIN);
            5'b11001: push(LOOUT | GRA | RIN);
            5'b11011: repeat (20) q.push_back('{vec: 32'd0, ir: cur_ir, con: cur_con});
            default: ;
        endcase
    endtask

    // Consume the expected trace one rising edge at a time.
    task automatic drain();
        int    budget;
        logic  stall;
        step_t h;
        budget = 0;
        while (q.size() > 0 && budget < 5000) begin
            h = q[0];
            @(posedge clock); #1;
            IR = h.ir; ConOut = h.con;
            #1;
            check("step", observed(), h.vec);
            stall = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
            stall     = ((h.vec & (MRD | MWR)) != 32'd0) && ($urandom_range(0, 2) == 0);
            mem_ready = !stall;
`endif
            if (!stall) void'(q.pop_front());
            budget++;
        end
        if (q.size() > 0) begin
            check("drain_budget", 32'(q.size()), 32'd0);
            q.delete();
        end
    endtask

    initial begin
        logic [4:0] op;
        IR = 32'd0; ConOut = 1'b0; clear = 1'b1;
`ifdef CTRL_MEM_WAIT_EN
        mem_ready = 1'b1;
`endif
        #1 clear = 1'b0;
        repeat (3) begin
            @(posedge clock); #2;
            check("reset", observed(), 32'd0);
        end
        clear = 1'b1;

        add_instr(5'b00011, 1'b0);
        add_instr(5'b00000, 1'b0);
        add_instr(5'b00010, 1'b0);
        add_instr(5'b10011, 1'b1);
        add_instr(5'b10011, 1'b0);
        add_instr(5'b11010, 1'b1);
        add_instr(5'b11110, 1'b0);
        repeat (40) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'b11011) op = 5'b11010;
            add_instr(op, 1'($urandom_range(0, 1)));
        end
        drain();

        add_instr(5'b11011, 1'b0);
        drain();

        clear = 1'b0;
        @(posedge clock); #2;
        clear = 1'b1;
        add_instr(5'b10000, 1'b0);
        void'(q.pop_back());
        void'(q.pop_back());
        drain();
        @(negedge clock); #1;
        check("mul_t5", observed(), RUN | ZLO | LOIN);
        clear = 1'b0;
        #1;
        check("async_clear", observed(), 32'd0);
        @(posedge clock); #1;
        check("no_loin", observed(), 32'd0);
        clear = 1'b1;
        add_instr(5'b10101, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d", tests);
        $fatal(1);
    end

endmodule
